mem_arbiter: RTL and testbench

Arbitrates a single shared main-memory port between the instruction-cache refill path and the data-cache path (line refills and write-through stores).
- Sits between the I-cache/D-cache miss logic and the backing memory model.
- Serialises requests, holds the memory handshake, and returns 128-bit lines.
- Guards each transaction with a watchdog so a lost acknowledge cannot hang the pipeline.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache refill path
// and the D-cache path (line reads and word write-through stores).
// One transaction at a time: IDLE (arbitrate) -> MEM (hold handshake) ->
// RESP (one-cycle ready pulse). A watchdog aborts a MEM phase that never
// sees mem_ack and raises a sticky err flag.
// Optional build macro DCACHE_PRIORITY_EN: the D side wins every tie instead
// of alternating with the I side.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_line,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_line,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  // owner / last_owner encoding: 0 = I side, 1 = D side
  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_q, err_d;
  logic              pick_d;

  // next-state: arbitration in IDLE, handshake + watchdog in MEM, pulse in RESP
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    line_d       = line_q;
    wdog_d       = wdog_q;
    err_d        = err_q;
    pick_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
`ifdef DCACHE_PRIORITY_EN
          pick_d = d_req;
`else
          // on a tie, serve the side that did not complete last
          pick_d = d_req && (!i_req || !last_owner_q);
`endif
          owner_d = pick_d;
          addr_d  = pick_d ? d_addr : i_addr;
          we_d    = pick_d & d_we;
          wdata_d = pick_d ? d_wdata : 32'd0;
          wdog_d  = '0;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          // an ack on the final watchdog cycle still counts as success
          line_d       = mem_rdata;
          last_owner_d = owner_q;
          state_d      = S_RESP;
        end else if (wdog_q == WD_LAST) begin
          err_d   = 1'b1;
          line_d  = '0;
          state_d = S_RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      line_q       <= '0;
      wdog_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      line_q       <= line_d;
      wdog_q       <= wdog_d;
      err_q        <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_req   = (state_q == S_MEM);
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign i_ready   = (state_q == S_RESP) && !owner_q;
  assign d_ready   = (state_q == S_RESP) && owner_q;
  assign i_line    = line_q;
  assign d_line    = line_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic.
// The bench plays both requesters and the memory; expectations come from a
// transaction-level model (winner choice, expected line, sticky error flag).
module tb_mem_arbiter;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [31:0]  i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [127:0] mem_rdata = '0;
  logic         i_ready, d_ready, mem_req, mem_we, busy, err;
  logic [127:0] i_line, d_line;
  logic [31:0]  mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;
  bit m_last = 1'b0;  // side that last completed with an ack (1 = D)
  bit m_err  = 1'b0;
  bit g_win;          // winner of the most recent serve

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_line(i_line),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_line(d_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    rst = 1'b0; i_req = 0; d_req = 0; mem_ack = 0;
    m_last = 1'b0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);    chk("rst_mem_req", mem_req, 0);
    chk("rst_i_ready", i_ready, 0); chk("rst_d_ready", d_ready, 0);
    chk("rst_err", err, 0);      chk("rst_line", d_line, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge with the arbiter idle and at least one request
  // driven. ack_lat = MEM cycle index on which memory acks; out of range
  // means memory never answers.
  task automatic serve(input int ack_lat, input logic [127:0] rd);
    bit win_d, to;
    logic [31:0] ea, ewd;
    bit ewe;
    int n;
    logic [127:0] eline;
    // a tie goes to the side other than the previous owner
    if (i_req && d_req) begin
`ifdef DCACHE_PRIORITY_EN
      win_d = 1'b1;
`else
      win_d = (m_last == 1'b0);
`endif
    end else win_d = d_req;
    g_win = win_d;
    ea    = win_d ? d_addr : i_addr;
    ewe   = win_d ? d_we : 1'b0;
    ewd   = d_wdata;
    to    = !(ack_lat >= 0 && ack_lat < TO);
    n     = to ? TO - 1 : ack_lat;
    eline = to ? '0 : rd;
    @(negedge clk);
    for (int k = 0; k <= n; k++) begin
      chk("mem_req", mem_req, 1); chk("mem_busy", busy, 1);
      chk("mem_addr", mem_addr, ea); chk("mem_we", mem_we, ewe);
      if (win_d) chk("mem_wdata", mem_wdata, ewd);
      chk("mem_no_ready", {i_ready, d_ready}, 0);
      if (k == ack_lat) begin mem_ack = 1'b1; mem_rdata = rd; end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = rnd128();
    end
    if (to) m_err = 1'b1; else m_last = win_d;
    chk("resp_i_ready", i_ready, !win_d);
    chk("resp_d_ready", d_ready, win_d);
    chk("resp_line", win_d ? d_line : i_line, eline);
    chk("resp_mem_req", mem_req, 0);
    chk("resp_err", err, m_err);
    if (win_d) d_req = 1'b0; else i_req = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ready", {i_ready, d_ready}, 0);
    chk("idle_line_hold", win_d ? d_line : i_line, eline);
  endtask

  initial begin
    do_reset();

    // lone I read, ack on 5th MEM cycle
    i_req = 1; i_addr = 32'h0040_0010;
    serve(4, {16{8'hAA}});
    chk("i_line_aa", i_line, {16{8'hAA}});

    // D write-through
    d_req = 1; d_we = 1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
    serve(3, rnd128());

    // simultaneous requests after reset: D, I, D, I
    do_reset();
    i_req = 1; i_addr = 32'h0000_1000; d_req = 1; d_we = 0; d_addr = 32'h2000_0040;
    serve(1, rnd128()); chk("order0", g_win, 1);
    serve(0, rnd128()); chk("order1", g_win, 0);
    i_req = 1; i_addr = 32'h0000_1010; d_req = 1; d_addr = 32'h2000_0050;
    serve(2, rnd128()); chk("order2", g_win, 1);
    serve(0, rnd128()); chk("order3", g_win, 0);
    // last owner D, then a tie: round-robin picks I, priority build picks D
    d_req = 1; d_addr = 32'h2000_0060;
    serve(0, rnd128());
    i_req = 1; i_addr = 32'h0000_1020; d_req = 1; d_addr = 32'h2000_0070;
    serve(0, rnd128());
`ifdef DCACHE_PRIORITY_EN
    chk("tie_after_d", g_win, 1);
`else
    chk("tie_after_d", g_win, 0);
`endif
    serve(0, rnd128());

    // ack on the last watchdog cycle is a normal completion
    d_req = 1; d_we = 0; d_addr = 32'h3000_0000;
    serve(TO - 1, {4{32'h1234_5678}});
    chk("late_ack_err", err, 0);

    // no ack at all: timeout, zero line, sticky err
    d_req = 1; d_addr = 32'h3000_0010;
    serve(-1, rnd128());
    chk("wd_err", err, 1);
    i_req = 1; i_addr = 32'h0040_0020;
    serve(2, rnd128());
    chk("wd_err_sticky", err, 1);

    // reset in the middle of MEM aborts immediately
    i_req = 1; i_addr = 32'h0040_0030;
    @(negedge clk);
    chk("pre_rst_mem_req", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_mem_req", mem_req, 0); chk("async_busy", busy, 0);
    chk("async_ready", {i_ready, d_ready}, 0); chk("async_err", err, 0);
    i_req = 0; m_last = 1'b0; m_err = 1'b0;
    @(negedge clk);
    chk("rst_hold_ready", {i_ready, d_ready}, 0);
    rst = 1'b1;
    @(negedge clk);
    i_req = 1; i_addr = 32'h0040_0040;
    serve(1, rnd128());

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1; d_addr = $urandom; d_we = $urandom_range(0, 1) == 1; d_wdata = $urandom;
      end
      if (!i_req && !d_req) begin i_req = 1; i_addr = $urandom; end
      serve(int'($urandom_range(0, TO + 1)), rnd128());
    end
    if (i_req || d_req) serve(0, rnd128());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
